divider8bit: RTL and testbench

DIVIDER8BIT -- requirements
Module: divider8bit

---
 rtl/divider8bit.sv | 136 +++++++++++++
 tb/tb_divider8bit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider8bit.sv
// ============================================================================
// Module   : divider8bit
// Purpose  : Signed 8-bit sequential divider. A restoring shift-subtract core
//            works on operand magnitudes, one quotient bit per clock, and the
//            signs are applied in a final step. Truncates toward zero; a
//            nonzero remainder carries the sign of the dividend.
// Ports    : clk         - rising-edge clock
//            rst         - asynchronous active-high reset
//            start       - request a division (accepted only in IDLE)
//            a, b        - signed dividend / divisor, sampled at acceptance
//            quotient    - registered signed quotient
//            remainder   - registered signed remainder
//            busy        - high while the division is in progress
//            done        - one-cycle pulse when results are valid
//            div_by_zero - sticky: last result was a divide by zero
//            OF          - sticky: last result overflowed (-128 / -1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic       OF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  step_q;
    logic [7:0]  dvd_q;      // dividend magnitude, shifted out MSB first; quotient bits shift in
    logic [7:0]  dvs_q;      // divisor magnitude
    logic [8:0]  rem_q;      // partial remainder
    logic        quo_neg_q;  // quotient must be negated
    logic        rem_neg_q;  // remainder must be negated

    logic [9:0]  shift_d;
    logic        fits_d;
    logic [8:0]  rem_d;
    logic [7:0]  dvd_d;

    // One restoring iteration: bring in the next dividend bit, subtract the
    // divisor if it fits and record the quotient bit in the vacated LSB.
    always_comb begin
        shift_d = {rem_q, dvd_q[7]};
        fits_d  = (shift_d >= {2'b00, dvs_q});
        rem_d   = fits_d ? 9'(shift_d - {2'b00, dvs_q}) : shift_d[8:0];
        dvd_d   = {dvd_q[6:0], fits_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            dvd_q       <= 8'h00;
            dvs_q       <= 8'h00;
            rem_q       <= 9'h000;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient    <= 8'h00;
            remainder   <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            OF          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (b == 8'h00) begin
                            // Divide by zero skips the iterations entirely.
                            quotient    <= 8'hFF;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            OF          <= 1'b0;
                            done        <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            // Negating 8'h80 in 8 bits yields 8'h80, the correct magnitude.
                            dvd_q     <= a[7] ? 8'(-a) : a;
                            dvs_q     <= b[7] ? 8'(-b) : b;
                            rem_q     <= 9'h000;
                            quo_neg_q <= a[7] ^ b[7];
                            rem_neg_q <= a[7];
                            step_q    <= 3'd0;
                            busy      <= 1'b1;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q  <= rem_d;
                    dvd_q  <= dvd_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    quotient    <= quo_neg_q ? 8'(-dvd_q) : dvd_q;
                    remainder   <= rem_neg_q ? 8'(-rem_q[7:0]) : rem_q[7:0];
                    div_by_zero <= 1'b0;
                    // A positive quotient of magnitude 128 only arises from -128 / -1.
                    OF          <= ~quo_neg_q & dvd_q[7];
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider8bit.sv
// ============================================================================
// Module   : tb_divider8bit
// Purpose  : Self-checking bench for divider8bit. Expected results come from
//            an integer reference model and travel through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_divider8bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       OF;

    divider8bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .OF          (OF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   sx;
        int   sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        e  = '0;
        if (sy == 0) begin
            e.q   = 8'hFF;
            e.r   = x;
            e.dbz = 1'b1;
        end else if (sx == -128 && sy == -1) begin
            e.q   = 8'h80;
            e.r   = 8'h00;
            e.ovf = 1'b1;
        end else begin
            e.q = 8'(sx / sy);
            e.r = 8'(sx % sy);
        end
        return e;
    endfunction

    // Drive a start request ahead of the next rising edge (edge 0).
    task automatic start_div(input logic [7:0] x, input logic [7:0] y, input bit push);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) sb_q.push_back(model(x, y));
    endtask

    // Consume edge 0, then count edges until done; lat = -1 on timeout.
    task automatic wait_done(output int lat, output bit saw_busy);
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        saw_busy = busy;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) saw_busy = 1'b1;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        start = 1'b1;
        a     = 8'h64;
        b     = 8'h07;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({quotient, remainder, busy, done, div_by_zero, OF} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b of=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero, OF);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_arith;
        logic [15:0] vecs [10];
        int          lat;
        bit          sbusy;
        exp_t        e;
        vecs = '{16'h6407, 16'h9C07, 16'h64F9, 16'h80FF, 16'h8001,
                 16'h0005, 16'h7F80, 16'hFFFF, 16'h8080, 16'h0DFC};
        for (int i = 0; i < 10; i++) begin
            start_div(vecs[i][15:8], vecs[i][7:0], 1'b1);
            wait_done(lat, sbusy);
            n_vec++;
            if (lat !== 9 || sbusy !== 1'b1) begin
                n_err++;
                $display("FAIL arith_latency[%0d]: got done at edge %0d busy_seen=%b, want edge 9 busy_seen=1",
                         i, lat, sbusy);
            end
            e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
            n_vec++;
            if ({quotient, remainder, div_by_zero, OF} !== e) begin
                n_err++;
                $display("FAIL arith_result[%0d] %h/%h: got q=%h r=%h dbz=%b of=%b, want q=%h r=%h dbz=%b of=%b",
                         i, vecs[i][15:8], vecs[i][7:0], quotient, remainder, div_by_zero, OF,
                         e.q, e.r, e.dbz, e.ovf);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL arith_done_width[%0d]: got done=%b at edge 10, want 0", i, done);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [15:0] vecs [3];
        int          want_lat [3];
        int          lat;
        bit          sbusy;
        exp_t        e;
        vecs     = '{16'h2A00, 16'h0903, 16'h8000};
        want_lat = '{0, 9, 0};
        for (int i = 0; i < 3; i++) begin
            start_div(vecs[i][15:8], vecs[i][7:0], 1'b1);
            wait_done(lat, sbusy);
            n_vec++;
            if (lat !== want_lat[i] || sbusy !== (want_lat[i] != 0)) begin
                n_err++;
                $display("FAIL dbz_latency[%0d]: got edge %0d busy_seen=%b, want edge %0d busy_seen=%b",
                         i, lat, sbusy, want_lat[i], (want_lat[i] != 0));
            end
            e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
            n_vec++;
            if ({quotient, remainder, div_by_zero, OF} !== e) begin
                n_err++;
                $display("FAIL dbz_result[%0d]: got q=%h r=%h dbz=%b of=%b, want q=%h r=%h dbz=%b of=%b",
                         i, quotient, remainder, div_by_zero, OF, e.q, e.r, e.dbz, e.ovf);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL dbz_done_width[%0d]: got done=%b one edge later, want 0", i, done);
            end
        end
    endtask

    task automatic test_ignore_start;
        int         n_done;
        int         first_done;
        logic [17:0] got;
        exp_t       e;
        n_done     = 0;
        first_done = -1;
        got        = '0;
        start_div(8'd100, 8'd7, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 3 || k == 9) begin
                start = 1'b1;
                a     = 8'($urandom_range(1, 255));
                b     = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    got        = {quotient, remainder, div_by_zero, OF};
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (n_done !== 1 || first_done !== 9) begin
            n_err++;
            $display("FAIL ignore_start_done: got %0d pulses first at edge %0d, want 1 pulse at edge 9",
                     n_done, first_done);
        end
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL ignore_start_result: got %h, want %h", got, e);
        end
    endtask

    task automatic test_back_to_back;
        int   n_done;
        int   d_edge [2];
        exp_t e;
        n_done = 0;
        d_edge = '{-1, -1};
        start_div(8'd50, 8'd6, 1'b1);
        @(posedge clk);
        #1;
        // Start stays high; new operands are what edge 11 should pick up.
        a = 8'hB3;
        b = 8'h05;
        sb_q.push_back(model(8'hB3, 8'h05));
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            if (k == 10 || k == 11) begin
                n_vec++;
                if (busy !== (k == 11)) begin
                    n_err++;
                    $display("FAIL b2b_busy_edge%0d: got busy=%b, want %b", k, busy, (k == 11));
                end
            end
            if (done) begin
                if (n_done < 2) d_edge[n_done] = k;
                n_done++;
                e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
                n_vec++;
                if ({quotient, remainder, div_by_zero, OF} !== e) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got q=%h r=%h dbz=%b of=%b, want q=%h r=%h dbz=%b of=%b",
                             n_done, quotient, remainder, div_by_zero, OF, e.q, e.r, e.dbz, e.ovf);
                end
            end
            if (k == 20) start = 1'b0;
        end
        start = 1'b0;
        n_vec++;
        if (n_done !== 2 || d_edge[0] !== 9 || d_edge[1] !== 20) begin
            n_err++;
            $display("FAIL b2b_timing: got %0d pulses at edges %0d,%0d, want 2 at edges 9,20",
                     n_done, d_edge[0], d_edge[1]);
        end
    endtask

    task automatic test_reset_mid_run;
        int   lat;
        bit   sbusy;
        exp_t e;
        start_div(8'd100, 8'd7, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({quotient, remainder, busy, done, div_by_zero, OF} !== 20'h0) begin
            n_err++;
            $display("FAIL midrun_reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b of=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero, OF);
        end
        // Release reset with start already high: the very next edge must accept it.
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        a     = 8'h9C;
        b     = 8'h07;
        sb_q.push_back(model(8'h9C, 8'h07));
        wait_done(lat, sbusy);
        n_vec++;
        if (lat !== 9) begin
            n_err++;
            $display("FAIL midrun_restart_latency: got done at edge %0d, want edge 9", lat);
        end
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        n_vec++;
        if ({quotient, remainder, div_by_zero, OF} !== e) begin
            n_err++;
            $display("FAIL midrun_restart_result: got q=%h r=%h dbz=%b of=%b, want q=%h r=%h dbz=%b of=%b",
                     quotient, remainder, div_by_zero, OF, e.q, e.r, e.dbz, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        n_vec++;
        if (sb_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
